// File: rtl/multi_channel_signal_shifter.sv
// N-channel programmable trigger delay. Each channel counts qualified edges on its async input.
// After the programmed edge count it waits a programmed delay, then emits a programmed-width pulse.
module multi_channel_signal_shifter #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DELAY_WIDTH  = 32,
  parameter int unsigned EVENT_WIDTH  = 8,
  parameter int unsigned PULSE_WIDTH  = 16,
  parameter int unsigned CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    cfg_write,
  input  logic [CH_WIDTH-1:0]     cfg_channel,
  input  logic [1:0]              cfg_sel,
  input  logic [DELAY_WIDTH-1:0]  cfg_data,
  input  logic [NUM_CHANNELS-1:0] input_signal,
  output logic [NUM_CHANNELS-1:0] output_signal,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic [NUM_CHANNELS-1:0] missed_event
);

  typedef enum logic [1:0] {StIdle, StDelay, StPulse} state_e;

  localparam logic [EVENT_WIDTH:0]   EvOne  = (EVENT_WIDTH + 1)'(1);
  localparam logic [PULSE_WIDTH-1:0] PwOne  = PULSE_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] CntOne = DELAY_WIDTH'(1);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [2:0]             r_sync;  // [0] s1, [1] s2, [2] s3 (previous s2 for edge detect)
    logic [DELAY_WIDTH-1:0] r_delay;
    logic [EVENT_WIDTH-1:0] r_event;
    logic [PULSE_WIDTH-1:0] r_pulse;
    logic [1:0]             r_mode;
    state_e                 r_state;
    logic [EVENT_WIDTH-1:0] r_ev_cnt;
    logic [DELAY_WIDTH-1:0] r_cnt;
    logic [DELAY_WIDTH-1:0] r_delay_act;
    logic [PULSE_WIDTH-1:0] r_pulse_act;
    logic                   r_out;
    logic                   r_busy;
    logic                   r_missed;

    logic                   w_edge;
    logic                   w_qual;
    logic                   w_cfg_hit;
    logic [EVENT_WIDTH:0]   w_ev_next;
    logic [EVENT_WIDTH:0]   w_ev_eff;
    logic [PULSE_WIDTH-1:0] w_pulse_eff;

    always_comb begin
      w_edge = 1'b0;
      case (r_mode)
        2'd0:    w_edge = r_sync[1] & ~r_sync[2];
        2'd1:    w_edge = ~r_sync[1] & r_sync[2];
        2'd2:    w_edge = r_sync[1] ^ r_sync[2];
        default: w_edge = 1'b0;
      endcase
    end

    assign w_qual      = w_edge & enable[i];
    assign w_cfg_hit   = cfg_write && (cfg_channel == CH_WIDTH'(i));
    assign w_ev_next   = {1'b0, r_ev_cnt} + EvOne;
    assign w_ev_eff    = (r_event == '0) ? EvOne : {1'b0, r_event};
    assign w_pulse_eff = (r_pulse == '0) ? PwOne : r_pulse;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_sync <= 3'b000;
      end else begin
        r_sync <= {r_sync[1:0], input_signal[i]};
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_delay <= '0;
        r_event <= EVENT_WIDTH'(1);
        r_pulse <= PwOne;
        r_mode  <= 2'd0;
      end else if (w_cfg_hit) begin
        unique case (cfg_sel)
          2'd0: r_delay <= cfg_data;
          2'd1: r_event <= cfg_data[EVENT_WIDTH-1:0];
          2'd2: r_pulse <= cfg_data[PULSE_WIDTH-1:0];
          2'd3: r_mode  <= cfg_data[1:0];
        endcase
      end
    end

    // Trigger decisions read the cfg registers before any same-cycle write lands.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_state     <= StIdle;
        r_ev_cnt    <= '0;
        r_cnt       <= '0;
        r_delay_act <= '0;
        r_pulse_act <= PwOne;
        r_out       <= 1'b0;
        r_busy      <= 1'b0;
        r_missed    <= 1'b0;
      end else if (!enable[i]) begin
        r_state  <= StIdle;
        r_ev_cnt <= '0;
        r_cnt    <= '0;
        r_out    <= 1'b0;
        r_busy   <= 1'b0;
        r_missed <= 1'b0;
      end else begin
        r_missed <= 1'b0;
        case (r_state)
          StIdle: begin
            if (w_qual) begin
              if (w_ev_next >= w_ev_eff) begin
                r_ev_cnt    <= '0;
                r_delay_act <= r_delay;
                r_pulse_act <= w_pulse_eff;
                r_busy      <= 1'b1;
                r_cnt       <= CntOne;
                if (r_delay == '0) begin
                  r_state <= StPulse;
                  r_out   <= 1'b1;
                end else begin
                  r_state <= StDelay;
                end
              end else begin
                r_ev_cnt <= w_ev_next[EVENT_WIDTH-1:0];
              end
            end
          end
          StDelay: begin
            r_missed <= w_qual;
            if (r_cnt >= r_delay_act) begin
              r_state <= StPulse;
              r_out   <= 1'b1;
              r_cnt   <= CntOne;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
          StPulse: begin
            r_missed <= w_qual;
            if (r_cnt >= DELAY_WIDTH'(r_pulse_act)) begin
              r_state <= StIdle;
              r_out   <= 1'b0;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
          default: begin
            r_state <= StIdle;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign output_signal[i] = r_out;
    assign busy[i]          = r_busy;
    assign missed_event[i]  = r_missed;
  end

endmodule

// File: tb/tb_multi_channel_signal_shifter.sv
// Bench for multi_channel_signal_shifter: directed scenarios plus random traffic, all checked
// against a time-window reference model of each channel.
module tb_multi_channel_signal_shifter;
  localparam int NCH  = 3;
  localparam int MAXC = 4096;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCH-1:0]  enable;
  logic            cfg_write;
  logic [1:0]      cfg_channel;
  logic [1:0]      cfg_sel;
  logic [31:0]     cfg_data;
  logic [NCH-1:0]  input_signal;
  logic [NCH-1:0]  output_signal;
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  missed_event;

  multi_channel_signal_shifter #(.NUM_CHANNELS(NCH)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_write    (cfg_write),
    .cfg_channel  (cfg_channel),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .input_signal (input_signal),
    .output_signal(output_signal),
    .busy         (busy),
    .missed_event (missed_event)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: per channel, the busy and output windows are absolute cycle ranges.
  int     busy_lo [NCH], busy_hi [NCH], out_lo [NCH], out_hi [NCH], miss_at [NCH], ev_cnt [NCH];
  longint m_delay [NCH];
  int     m_event [NCH], m_pulse [NCH], m_mode [NCH];
  bit     hist [NCH][MAXC];
  int     last_rst = -1;
  logic [NCH-1:0] exp_out, exp_busy, exp_miss;

  function automatic bit hval(int ch, int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    return hist[ch][k];
  endfunction

  task automatic model_cycle();
    int c;
    c = cyc;
    if (!reset_n) begin
      last_rst = c;
      for (int ch = 0; ch < NCH; ch++) begin
        busy_lo[ch] = 0; busy_hi[ch] = -1; out_lo[ch] = 0; out_hi[ch] = -1;
        miss_at[ch] = -1; ev_cnt[ch] = 0;
        m_delay[ch] = 0; m_event[ch] = 1; m_pulse[ch] = 1; m_mode[ch] = 0;
      end
      return;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      bit a, b, e;
      int eff, p, d;
      if (c < MAXC) hist[ch][c] = input_signal[ch];
      a = hval(ch, c - 2);
      b = hval(ch, c - 3);
      case (m_mode[ch])
        0:       e = a && !b;
        1:       e = !a && b;
        2:       e = a != b;
        default: e = 1'b0;
      endcase
      if (!enable[ch]) begin
        ev_cnt[ch] = 0;
        if (busy_hi[ch] > c) busy_hi[ch] = c;
        if (out_hi[ch] > c) out_hi[ch] = c;
      end else if (e) begin
        if (c >= busy_lo[ch] && c <= busy_hi[ch]) begin
          miss_at[ch] = c + 1;
        end else begin
          ev_cnt[ch]++;
          eff = (m_event[ch] == 0) ? 1 : m_event[ch];
          if (ev_cnt[ch] >= eff) begin
            ev_cnt[ch] = 0;
            d = int'(m_delay[ch]);
            p = (m_pulse[ch] == 0) ? 1 : m_pulse[ch];
            busy_lo[ch] = c + 1;
            busy_hi[ch] = c + d + p;
            out_lo[ch]  = c + 1 + d;
            out_hi[ch]  = c + d + p;
          end
        end
      end
    end
    if (cfg_write && int'(cfg_channel) < NCH) begin
      case (cfg_sel)
        2'd0: m_delay[cfg_channel] = longint'(cfg_data);
        2'd1: m_event[cfg_channel] = int'(cfg_data[7:0]);
        2'd2: m_pulse[cfg_channel] = int'(cfg_data[15:0]);
        default: m_mode[cfg_channel] = int'(cfg_data[1:0]);
      endcase
    end
  endtask

  // Advance one cycle; afterwards we sit at the falling edge with exp_* valid for cycle cyc.
  task automatic tick();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      exp_out[ch]  = (cyc >= out_lo[ch] && cyc <= out_hi[ch]);
      exp_busy[ch] = (cyc >= busy_lo[ch] && cyc <= busy_hi[ch]);
      exp_miss[ch] = (miss_at[ch] == cyc);
    end
  endtask

  task automatic cfg(input int ch, input int sel, input int data);
    cfg_write   = 1'b1;
    cfg_channel = ch[1:0];
    cfg_sel     = sel[1:0];
    cfg_data    = data;
    tick();
    cfg_write   = 1'b0;
  endtask

  task automatic test_reset();
    int n_hi;
    n_hi = 0;
    reset_n = 1'b0; enable = '1; input_signal = 3'b001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d out/busy/miss=%b/%b/%b want all 0", cyc,
                 output_signal, busy, missed_event);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (output_signal[0]) n_hi++;
    end
    n_assert++;
    if (n_hi !== 1) begin
      n_fail++;
      $display("FAIL held_high_edge ch0 pulse cycles=%0d want 1", n_hi);
    end
    input_signal = 3'b000;
  endtask

  task automatic test_ch0_delay();
    int d, first_hi, n_hi;
    cfg(0, 0, 10); cfg(0, 2, 3);
    d = cyc + 4; first_hi = -1; n_hi = 0;
    while (cyc < d + 25) begin
      if (cyc == d) input_signal[0] = 1'b1;
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL ch0_delay cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (output_signal[0]) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
      end
    end
    n_assert++;
    if (first_hi !== d + 13 || n_hi !== 3) begin
      n_fail++;
      $display("FAIL ch0_pulse_timing first=%0d len=%0d want first=%0d len=3", first_hi, n_hi,
               d + 13);
    end
  endtask

  task automatic test_event_count();
    int d, d3, first_hi, n_hi;
    cfg(1, 1, 3); cfg(1, 3, 1);
    input_signal[1] = 1'b1;
    d = cyc + 6; d3 = d + 20; first_hi = -1; n_hi = 0;
    while (cyc < d3 + 12) begin
      // fall, rise, fall, rise, fall at 5-cycle spacing
      if (cyc >= d && cyc <= d3 && (cyc - d) % 5 == 0) input_signal[1] = ~input_signal[1];
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL event_count cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (output_signal[1]) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
      end
    end
    n_assert++;
    if (first_hi !== d3 + 3 || n_hi !== 1) begin
      n_fail++;
      $display("FAIL ch1_third_fall first=%0d len=%0d want first=%0d len=1", first_hi, n_hi,
               d3 + 3);
    end
  endtask

  task automatic test_both_edges();
    int d, first_hi, n_hi, n_busy;
    cfg(2, 3, 2);
    d = cyc + 4; first_hi = -1; n_hi = 0; n_busy = 0;
    while (cyc < d + 10) begin
      if (cyc == d) input_signal[2] = 1'b1;
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL both_edges cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (output_signal[2]) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
      end
      if (busy[2]) n_busy++;
    end
    n_assert++;
    if (first_hi !== d + 3 || n_hi !== 1 || n_busy !== 1) begin
      n_fail++;
      $display("FAIL ch2_zero_delay first=%0d len=%0d busy=%0d want first=%0d len=1 busy=1",
               first_hi, n_hi, n_busy, d + 3);
    end
  endtask

  task automatic test_missed();
    int d, first_hi, n_hi, n_miss;
    cfg(0, 0, 20);
    input_signal[0] = 1'b0;
    d = cyc + 5; first_hi = -1; n_hi = 0; n_miss = 0;
    while (cyc < d + 40) begin
      if (cyc == d)     input_signal[0] = 1'b1;
      if (cyc == d + 3) input_signal[0] = 1'b0;
      if (cyc == d + 5) input_signal[0] = 1'b1;
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL missed cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (output_signal[0]) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
      end
      if (missed_event[0]) n_miss++;
      if (cyc == d + 8) begin
        n_assert++;
        if (missed_event[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL missed_strobe cyc=%0d got %b want 1", cyc, missed_event[0]);
        end
      end
    end
    n_assert++;
    if (first_hi !== d + 23 || n_hi !== 3 || n_miss !== 1) begin
      n_fail++;
      $display("FAIL missed_single_pulse first=%0d len=%0d miss=%0d want %0d/3/1", first_hi,
               n_hi, n_miss, d + 23);
    end
  endtask

  task automatic test_enable_drop();
    int d, first_hi, n_hi;
    input_signal[0] = 1'b0;
    d = cyc + 4; first_hi = -1; n_hi = 0;
    while (cyc < d + 50) begin
      if (cyc == d)      input_signal[0] = 1'b1;
      if (cyc == d + 7)  enable[0] = 1'b0;
      if (cyc == d + 8)  input_signal[0] = 1'b0;
      if (cyc == d + 10) enable[0] = 1'b1;
      if (cyc == d + 14) input_signal[0] = 1'b1;
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL enable_drop cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (cyc == d + 8) begin
        n_assert++;
        if (busy[0] !== 1'b0 || output_signal[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL enable_cancel cyc=%0d busy=%b out=%b want 0/0", cyc, busy[0],
                   output_signal[0]);
        end
      end
      if (output_signal[0]) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc;
      end
    end
    n_assert++;
    if (first_hi !== d + 37 || n_hi !== 3) begin
      n_fail++;
      $display("FAIL reenable_fresh_delay first=%0d len=%0d want %0d/3", first_hi, n_hi, d + 37);
    end
  endtask

  task automatic test_bad_cfg_reset();
    int d;
    cfg(3, 0, 2); cfg(3, 3, 3); cfg(1, 1, 1);
    input_signal = 3'b010;
    d = cyc + 8;
    while (cyc < d + 35) begin
      if (cyc == d) input_signal = 3'b101;
      reset_n = (cyc == d + 24) ? 1'b0 : 1'b1;
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL bad_cfg_reset cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
      if (cyc == d + 23 || cyc == d + 24) begin
        n_assert++;
        if (output_signal[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bad_channel_ignored cyc=%0d out0=%b want 1", cyc, output_signal[0]);
        end
      end
      if (cyc == d + 25) begin
        n_assert++;
        if ({output_signal, busy, missed_event} !== 9'b0) begin
          n_fail++;
          $display("FAIL reset_mid_pulse got %b/%b/%b want all 0", output_signal, busy,
                   missed_event);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] data;
    for (int k = 0; k < 1500; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 5) == 0) input_signal[ch] = ~input_signal[ch];
        if ($urandom_range(0, 59) == 0) enable[ch] = ~enable[ch];
      end
      cfg_write   = ($urandom_range(0, 11) == 0);
      cfg_channel = 2'($urandom_range(0, 3));
      cfg_sel     = 2'($urandom_range(0, 3));
      case (cfg_sel)
        2'd0:    data = $urandom_range(0, 8);
        2'd1:    data = $urandom_range(0, 3);
        2'd2:    data = $urandom_range(0, 4);
        default: data = $urandom_range(0, 3);
      endcase
      cfg_data = data;
      reset_n  = ($urandom_range(0, 399) != 0);
      tick();
      n_assert++;
      if ({output_signal, busy, missed_event} !== {exp_out, exp_busy, exp_miss}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %b/%b/%b want %b/%b/%b", cyc, output_signal,
                 busy, missed_event, exp_out, exp_busy, exp_miss);
      end
    end
    cfg_write = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = '0; cfg_write = 1'b0; cfg_channel = '0; cfg_sel = '0;
    cfg_data = '0; input_signal = '0;
    test_reset();
    test_ch0_delay();
    test_event_count();
    test_both_edges();
    test_missed();
    test_enable_drop();
    test_bad_cfg_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
